avalon_burst_sequencer: RTL and testbench
=========================================

// Module: avalon_burst_sequencer
// PURPOSE
//  Command stage directly upstream of the Avalon master FIFO. Accepts one large
//  read/write request (byte address + word count) and splits it into Avalon bursts
//  of at most MAX_BURST_LEN words. Drives the FIFO's command channel one burst at
//  a time and waits for the FIFO's done pulse before issuing the next burst.
// PARAMETERS
//  C_AVM_ADDR_WIDTH  32   byte address width
//  C_AVM_DATA_WIDTH  32   data width in bits; BPW = C_AVM_DATA_WIDTH/8 bytes per word, power of 2
//  SIZE_WIDTH        32   width of the request word count
//  MAX_BURST_LEN     256  max words per burst, 1..256
//  BURST_BOUNDARY    4096 byte boundary that bursts must not cross (macro only), power of 2, >= BPW
// PORTS
//  ACLK               in   1          clock
//  ARESET             in   1          synchronous, active-high reset
//  req_valid          in   1          request present
//  req_ready          out  1          request accepted when req_valid && req_ready
//  req_write          in   1          1 = write, 0 = read
//  req_addr           in   C_AVM_ADDR_WIDTH  start byte address; low log2(BPW) bits ignored
//  req_size           in   SIZE_WIDTH total words
//  cmd_busy           out  1          request in progress
//  cmd_done           out  1          1-cycle pulse when the whole request has completed
//  user_addr          out  C_AVM_ADDR_WIDTH  burst byte address to FIFO
//  user_read_enable   out  1          read burst command to FIFO
//  user_write_enable  out  1          write burst command to FIFO
//  user_word_size     out  9          burst length to FIFO, 1..MAX_BURST_LEN
//  user_done          in   1          FIFO 1-cycle pulse: current burst complete
// BEHAVIOUR
//  - Reset values: req_ready=0 for the cycle ARESET is high, then 1 in IDLE.
//    cmd_busy=0, cmd_done=0, user_addr=0, user_read_enable=0, user_write_enable=0,
//    user_word_size=0. FSM=IDLE; remaining=0.
//  - Reset mid-operation: all state is dropped at the next edge, with no drain.
//    Any in-flight FIFO transfer must be reset together with this block.
//  - FSM states: IDLE, CALC, ISSUE, FIN.
//  - IDLE: req_ready=1.
//    - On accept, latch the direction, the aligned address (low bits zeroed) and
//      remaining=req_size.
//    - If req_size==0, go to FIN with no burst issued. Otherwise go to CALC.
//  - CALC (1 cycle, enables low):
//    - len = min(remaining, MAX_BURST_LEN).
//    - Register user_word_size=len and user_addr=cur_addr. Go to ISSUE.
//  - ISSUE:
//    - Assert user_read_enable or user_write_enable (per latched direction).
//      Addr and size are stable until user_done.
//    - On user_done:
//      - Drop the enable at that edge.
//      - remaining -= len; cur_addr += len*BPW. Address wraps modulo 2^C_AVM_ADDR_WIDTH.
//      - Go to CALC if remaining!=0, else FIN.
//  - FIN: cmd_done=1 for exactly one cycle, then IDLE. cmd_busy=1 in all states except IDLE.
//  - Enable-to-enable gap between bursts is exactly 2 cycles (done cycle + CALC).
//    This gives the FIFO a guaranteed enable-low cycle after its done ack.
//  - user_done outside ISSUE is ignored. req_valid outside IDLE is not accepted.
//  - Only one of user_read_enable/user_write_enable is ever high.
//  - Arithmetic: remaining is SIZE_WIDTH bits. len*BPW is computed in C_AVM_ADDR_WIDTH bits.
// CONFIGURATION
//  AVM_BURST_BOUNDARY_EN defined:
//    - CALC also limits len to the words left before the next BURST_BOUNDARY:
//      len = min(remaining, MAX_BURST_LEN, (BURST_BOUNDARY - cur_addr%BURST_BOUNDARY)/BPW).
//    - No burst crosses the boundary.
//  AVM_BURST_BOUNDARY_EN undefined:
//    - Only the remaining and MAX_BURST_LEN limits apply.
//    - BURST_BOUNDARY is unused.
// TESTING
//  Use the default parameters, BPW=4. The FIFO model returns user_done 5 cycles after the enable.
//  - Read, addr=0x100, size=600 -> 3 read bursts: (0x100,256), (0x500,256), (0x900,88).
//    One cmd_done, then IDLE.
//  - Write, addr=0x0, size=1 -> one write burst (0x0,1), cmd_done 1 cycle after FIN entry.
//  - size=0 -> no enable ever asserted; cmd_done pulses 2 cycles after accept.
//  - Reset asserted while in ISSUE of the 2nd of 3 bursts -> the next cycle shows:
//    all enables=0, cmd_busy=0, req_ready=0 (1 once reset is released).
//    No cmd_done pulse is produced.
//  - With AVM_BURST_BOUNDARY_EN: addr=0xF00, size=256 -> bursts (0xF00,64), (0x1000,192).
//    Without the macro -> a single burst (0xF00,256).
//  - Spurious user_done in IDLE, plus req_valid held during ISSUE ->
//    the spurious done is ignored and the request is accepted only after the FIN->IDLE transition.

Source files
------------

// File: rtl/avalon_burst_sequencer.sv
// avalon_burst_sequencer: splits one large read/write request into Avalon bursts of <= MAX_BURST_LEN words.
// Latency: first enable 2 cycles after accept, 2-cycle enable-to-enable gap, cmd_done 1 cycle after FIN.
// Backpressure: one burst outstanding, held until user_done; req_ready only in IDLE.
// Optional macro AVM_BURST_BOUNDARY_EN: additionally stop each burst at the next BURST_BOUNDARY.
module avalon_burst_sequencer #(
   parameter int C_AVM_ADDR_WIDTH = 32,
   parameter int C_AVM_DATA_WIDTH = 32,
   parameter int SIZE_WIDTH       = 32,
   parameter int MAX_BURST_LEN    = 256,
   parameter int BURST_BOUNDARY   = 4096
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [C_AVM_ADDR_WIDTH-1:0] req_addr,
   input  logic [SIZE_WIDTH-1:0]       req_size,
   output logic                        cmd_busy,
   output logic                        cmd_done,
   output logic [C_AVM_ADDR_WIDTH-1:0] user_addr,
   output logic                        user_read_enable,
   output logic                        user_write_enable,
   output logic [8:0]                  user_word_size,
   input  logic                        user_done
);

   localparam int AW  = C_AVM_ADDR_WIDTH;
   localparam int SW  = SIZE_WIDTH;
   localparam int BPW = C_AVM_DATA_WIDTH / 8;
   // Compare width large enough for any of the three length limits without overflow.
   localparam int CW  = ((SW > AW) ? SW : AW) + 1;

`ifdef AVM_BURST_BOUNDARY_EN
   localparam bit BOUNDARY_EN = 1'b1;
`else
   localparam bit BOUNDARY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, ISSUE, FIN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic            is_write;
   logic [AW-1:0]   cur_addr;
   logic [SW-1:0]   remaining;
   logic            req_fire;
   logic            last_burst;
   logic [AW-1:0]   bnd_off;
   logic [CW-1:0]   lim_rem;
   logic [CW-1:0]   lim_max;
   logic [CW-1:0]   lim_bnd;
   logic [CW-1:0]   len_a;
   logic [CW-1:0]   len_b;
   logic [8:0]      len;

   assign req_fire   = req_valid && req_ready;
   assign last_burst = (remaining == SW'(user_word_size));

   // Burst length: smallest of words remaining, MAX_BURST_LEN and (optionally) words left to the boundary.
   always_comb begin
      bnd_off = cur_addr & AW'(BURST_BOUNDARY - 1);
      lim_rem = CW'(remaining);
      lim_max = CW'(MAX_BURST_LEN);
      lim_bnd = (CW'(BURST_BOUNDARY) - CW'(bnd_off)) / CW'(BPW);
      len_a   = (lim_rem < lim_max) ? lim_rem : lim_max;
      len_b   = (BOUNDARY_EN && (lim_bnd < len_a)) ? lim_bnd : len_a;
      len     = 9'(len_b);
   end

   // State register; reset drops any request in flight.
   always_ff @(posedge ACLK) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_fire) state_nxt = (req_size == '0) ? FIN : CALC;
         CALC:    state_nxt = ISSUE;
         ISSUE:   if (user_done) state_nxt = last_burst ? FIN : CALC;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, per-burst command registers and the registered completion pulse.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         is_write       <= 1'b0;
         cur_addr       <= '0;
         remaining      <= '0;
         user_addr      <= '0;
         user_word_size <= '0;
         cmd_done       <= 1'b0;
      end else begin
         cmd_done <= (state == FIN);
         case (state)
            IDLE: begin
               if (req_fire) begin
                  is_write  <= req_write;
                  cur_addr  <= req_addr & ~AW'(BPW - 1);
                  remaining <= req_size;
               end
            end
            CALC: begin
               user_word_size <= len;
               user_addr      <= cur_addr;
            end
            ISSUE: begin
               if (user_done) begin
                  remaining <= remaining - SW'(user_word_size);
                  cur_addr  <= cur_addr + AW'(user_word_size) * AW'(BPW);
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake and command enables decoded from the state; req_ready held low while reset is high.
   always_comb begin
      req_ready         = (state == IDLE) && !ARESET;
      cmd_busy          = (state != IDLE);
      user_read_enable  = (state == ISSUE) && !is_write;
      user_write_enable = (state == ISSUE) && is_write;
   end

endmodule

// File: tb/tb_avalon_burst_sequencer.sv
// tb_avalon_burst_sequencer: directed and random requests checked against a burst-list reference model.
// The FIFO model answers each burst enable with a user_done pulse 5 cycles later.
// Exercises reset values, gaps, size 0, reset mid-burst, spurious done and held req_valid.
module tb_avalon_burst_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_size;
   logic        cmd_busy;
   logic        cmd_done;
   logic [31:0] user_addr;
   logic        user_read_enable;
   logic        user_write_enable;
   logic [8:0]  user_word_size;
   logic        user_done;

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [8:0]  n;
      int          rise;
      int          done;
   } burst_t;

   burst_t bq[$];
   burst_t exp_q[$];
   burst_t exp_a[$];
   int     done_q[$];
   int     cyc      = 0;
   int     both_err = 0;
   int     stab_err = 0;
   int     inj_req  = 0;
   int     inj_ack  = 0;
   int     n_pass   = 0;
   int     n_fail   = 0;
   int     n_checks = 0;

   avalon_burst_sequencer dut (
      .ACLK              (ACLK),
      .ARESET            (ARESET),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_size          (req_size),
      .cmd_busy          (cmd_busy),
      .cmd_done          (cmd_done),
      .user_addr         (user_addr),
      .user_read_enable  (user_read_enable),
      .user_write_enable (user_write_enable),
      .user_word_size    (user_word_size),
      .user_done         (user_done)
   );

   initial forever #5 ACLK = ~ACLK;

   initial forever begin
      @(posedge ACLK);
      cyc++;
   end

   initial begin
      #700000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // FIFO model and bus monitor, both acting at the falling edge.
   initial begin
      logic        en;
      logic        prev_en;
      logic [31:0] prev_a;
      logic [8:0]  prev_n;
      int          en_cnt;
      prev_en = 1'b0; prev_a = '0; prev_n = '0; en_cnt = 0;
      user_done = 1'b0;
      forever begin
         @(negedge ACLK);
         en = user_read_enable | user_write_enable;
         if (ARESET || en !== 1'b1) en_cnt = 0;
         else en_cnt++;
         user_done = (en_cnt == 6) || (inj_req != inj_ack);
         inj_ack = inj_req;
         if (user_read_enable === 1'b1 && user_write_enable === 1'b1) both_err++;
         if (en === 1'b1 && prev_en !== 1'b1)
            bq.push_back('{w: user_write_enable, a: user_addr, n: user_word_size, rise: cyc, done: -1});
         else if (en === 1'b1 && (user_addr !== prev_a || user_word_size !== prev_n))
            stab_err++;
         if (en === 1'b1 && user_done && bq.size() > 0) bq[bq.size()-1].done = cyc;
         if (cmd_done === 1'b1) done_q.push_back(cyc);
         prev_en = en; prev_a = user_addr; prev_n = user_word_size;
      end
   end

   task automatic chk(input string tag, input string what, input longint obs, input longint expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, expv);
      end
   endtask

   // Reference: walk the request with plain arithmetic and list the bursts it must produce.
   task automatic build_model(input bit w, input logic [31:0] addr, input logic [31:0] size);
      longint unsigned rem, len, ad;
      exp_q.delete();
      ad  = longint'(addr) & 64'hFFFF_FFFC;
      rem = longint'(size);
      while (rem != 0) begin
         len = (rem < 256) ? rem : 256;
`ifdef AVM_BURST_BOUNDARY_EN
         begin
            longint unsigned cap;
            cap = (4096 - (ad % 4096)) / 4;
            if (cap < len) len = cap;
         end
`endif
         exp_q.push_back('{w: w, a: ad[31:0], n: len[8:0], rise: 0, done: 0});
         rem = rem - len;
         ad  = (ad + len * 4) % 64'h1_0000_0000;
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic cmp_burst(input string tag, input int i, input int j);
      chk(tag, "burst_dir",  bq[i].w, exp_q[j].w);
      chk(tag, "burst_addr", bq[i].a, exp_q[j].a);
      chk(tag, "burst_len",  bq[i].n, exp_q[j].n);
   endtask

   task automatic run_req(input string tag, input bit w, input logic [31:0] a, input logic [31:0] s);
      int acc, t, nb;
      bq.delete(); done_q.delete();
      build_model(w, a, s);
      req_write = w; req_addr = a; req_size = s; req_valid = 1'b1;
      t = 0;
      while (req_ready !== 1'b1 && t < 50) begin step(); t++; end
      acc = cyc;
      step();
      req_valid = 1'b0;
      t = 0;
      while (done_q.size() == 0 && t < 1500) begin step(); t++; end
      repeat (3) step();
      chk(tag, "cmd_done_count", done_q.size(), 1);
      chk(tag, "burst_count", bq.size(), exp_q.size());
      chk(tag, "idle_ready", req_ready, 1);
      chk(tag, "idle_busy", cmd_busy, 0);
      nb = (bq.size() < exp_q.size()) ? bq.size() : exp_q.size();
      for (int i = 0; i < nb; i++) begin
         cmp_burst(tag, i, i);
         if (i > 0) chk(tag, "enable_gap", bq[i].rise - bq[i-1].done, 2);
      end
      if (done_q.size() > 0) begin
         if (exp_q.size() == 0) chk(tag, "done_after_accept", done_q[0] - acc, 2);
         else if (bq.size() > 0) begin
            chk(tag, "first_enable_lat", bq[0].rise - acc, 2);
            chk(tag, "done_after_last", done_q[0] - bq[bq.size()-1].done, 2);
         end
      end
   endtask

   initial begin
      int t;
      ARESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
      repeat (2) step();

      // Reset values while reset is held.
      chk("reset", "req_ready", req_ready, 0);
      chk("reset", "cmd_busy", cmd_busy, 0);
      chk("reset", "cmd_done", cmd_done, 0);
      chk("reset", "user_addr", user_addr, 0);
      chk("reset", "word_size", user_word_size, 0);
      chk("reset", "rd_en", user_read_enable, 0);
      chk("reset", "wr_en", user_write_enable, 0);
      ARESET = 1'b0;
      #1;
      chk("reset", "ready_after_release", req_ready, 1);
      step();

      // Directed cases.
      run_req("read600", 1'b0, 32'h100, 32'd600);
      if (bq.size() == 3) begin
         chk("read600", "b0_addr", bq[0].a, 32'h100);
         chk("read600", "b1_addr", bq[1].a, 32'h500);
         chk("read600", "b2_addr", bq[2].a, 32'h900);
         chk("read600", "b2_len", bq[2].n, 88);
      end
      run_req("write1", 1'b1, 32'h0, 32'd1);
      run_req("size0", 1'b1, 32'h1234, 32'd0);
      run_req("unaligned", 1'b0, 32'h203, 32'd5);
      run_req("boundary", 1'b1, 32'hF00, 32'd256);
`ifdef AVM_BURST_BOUNDARY_EN
      chk("boundary", "n_bursts_const", bq.size(), 2);
`else
      chk("boundary", "n_bursts_const", bq.size(), 1);
`endif
      run_req("wrap", 1'b0, 32'hFFFF_FF80, 32'd300);

      // Reset while the 2nd of 3 bursts is in ISSUE.
      bq.delete(); done_q.delete();
      req_write = 1'b0; req_addr = 32'h100; req_size = 32'd600; req_valid = 1'b1;
      t = 0;
      while (req_ready !== 1'b1 && t < 50) begin step(); t++; end
      step();
      req_valid = 1'b0;
      t = 0;
      while (!(bq.size() == 2 && user_read_enable === 1'b1) && t < 200) begin step(); t++; end
      chk("midreset", "reached_burst2", bq.size(), 2);
      ARESET = 1'b1;
      step();
      chk("midreset", "rd_en", user_read_enable, 0);
      chk("midreset", "wr_en", user_write_enable, 0);
      chk("midreset", "cmd_busy", cmd_busy, 0);
      chk("midreset", "req_ready", req_ready, 0);
      ARESET = 1'b0;
      #1;
      chk("midreset", "ready_after_release", req_ready, 1);
      repeat (12) step();
      chk("midreset", "no_cmd_done", done_q.size(), 0);
      chk("midreset", "no_more_bursts", bq.size(), 2);

      // Spurious done in IDLE, then a request held valid across a busy period.
      bq.delete(); done_q.delete();
      inj_req++;
      repeat (2) step();
      chk("spurious", "busy", cmd_busy, 0);
      chk("spurious", "ready", req_ready, 1);
      chk("spurious", "no_burst", bq.size(), 0);
      build_model(1'b1, 32'h40, 32'd3);
      exp_a = exp_q;
      build_model(1'b0, 32'h2000, 32'd300);
      req_write = 1'b1; req_addr = 32'h40; req_size = 32'd3; req_valid = 1'b1;
      step();
      req_write = 1'b0; req_addr = 32'h2000; req_size = 32'd300;
      t = 0;
      while (done_q.size() == 0 && t < 500) begin step(); t++; end
      req_valid = 1'b0;
      t = 0;
      while (done_q.size() < 2 && t < 1500) begin step(); t++; end
      repeat (3) step();
      chk("heldvalid", "cmd_done_count", done_q.size(), 2);
      chk("heldvalid", "burst_count", bq.size(), exp_a.size() + exp_q.size());
      if (bq.size() == 3 && done_q.size() == 2) begin
         chk("heldvalid", "a_dir", bq[0].w, exp_a[0].w);
         chk("heldvalid", "a_addr", bq[0].a, exp_a[0].a);
         chk("heldvalid", "a_len", bq[0].n, exp_a[0].n);
         cmp_burst("heldvalid", 1, 0);
         cmp_burst("heldvalid", 2, 1);
         chk("heldvalid", "b_after_a_done", bq[1].rise - done_q[0], 2);
      end

      // Random requests against the model.
      for (int i = 0; i < 14; i++) begin
         logic [31:0] a, s;
         a = $urandom;
         if (i % 4 == 0) a = 32'hFFFF_F000 | (a & 32'h0000_0FFF);
         s = $urandom_range(0, 1100);
         if (i % 5 == 0) s = 32'd0;
         if (i == 3) s = 32'd512;
         run_req("random", 1'($urandom_range(0, 1)), a, s);
      end

      chk("global", "enables_exclusive", both_err, 0);
      chk("global", "cmd_stable_in_issue", stab_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
